// File: rtl/div_sched_ctrl.sv
// Runtime-reconfigurable clock divider: period counter with one-cycle tick and a
// registered divided clock. New ratios, start and stop all take effect on a period boundary.
module div_sched_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 7,
    parameter int unsigned DIV_MIN     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             tick_o,
    output logic             clk_div_o,
    output logic [CNT_W-1:0] div_cur_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             tick_d, clk_div_d, busy_d, ready_d, err_d;
    logic             xfer, reject, accept, boundary, run_d;

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_cur_o;
        pend_d   = pend_q;
        xfer     = cfg_valid_i && cfg_ready_o;
        reject   = xfer && (cfg_div_i < DIV_LO);
        accept   = xfer && !reject;
        boundary = (state_q != IDLE) && (cnt_q == div_cur_o - ONE);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    div_d = cfg_div_i;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (!en_i) begin
                        // Stopping: nothing left to defer to, so a coincident update lands now.
                        state_d = IDLE;
                        if (accept) begin
                            div_d = cfg_div_i;
                        end
                    end else if (accept) begin
                        pend_d  = cfg_div_i;
                        state_d = PEND;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (accept) begin
                        pend_d  = cfg_div_i;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (boundary) begin
                    cnt_d   = '0;
                    div_d   = pend_q;
                    state_d = en_i ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        run_d     = (state_d != IDLE);
        tick_d    = run_d && (cnt_d == div_d - ONE);
        clk_div_d = run_d && (cnt_d < (div_d >> 1));
        busy_d    = run_d;
        ready_d   = (state_d != PEND);
        err_d     = reject;
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_cur_o   <= DIV_RST;
            pend_q      <= '0;
            tick_o      <= 1'b0;
            clk_div_o   <= 1'b0;
            cfg_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_cur_o   <= div_d;
            pend_q      <= pend_d;
            tick_o      <= tick_d;
            clk_div_o   <= clk_div_d;
            cfg_err_o   <= err_d;
            busy_o      <= busy_d;
            cfg_ready_o <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Bench for div_sched_ctrl: tick cycles are queued as stimulus is driven and
// popped by a tick monitor; waveform and handshake checks are inline per scenario.
module tb_div_sched_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             en_i = 1'b0;
    logic             cfg_valid_i = 1'b0;
    logic [CNT_W-1:0] cfg_div_i = '0;
    logic             cfg_ready_o, cfg_err_o, tick_o, clk_div_o, busy_o;
    logic [CNT_W-1:0] div_cur_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    div_sched_ctrl #(.CNT_W(CNT_W), .DIV_DEFAULT(7), .DIV_MIN(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_err_o   (cfg_err_o),
        .tick_o      (tick_o),
        .clk_div_o   (clk_div_o),
        .div_cur_o   (div_cur_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Tick scoreboard: every observed tick must match the next queued cycle.
    always @(negedge clk_i) begin
        if (!rst_i && tick_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tick_unexpected cyc=%0d got=tick exp=none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    bad++;
                    $display("FAIL tick_cycle got=%0d exp=%0d", cyc, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic drain(input string name);
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missed_ticks got=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset, then enable; returns the cycle showing phase 0 of the first period.
    task automatic start_run(output int p0);
        rst_i = 1'b1; en_i = 1'b0; cfg_valid_i = 1'b0; cfg_div_i = '0;
        step(); step();
        rst_i = 1'b0; en_i = 1'b1;
        step();
        p0 = cyc;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1;
        step(); step();
        total += 6;
        if (tick_o !== 1'b0)     begin bad++; $display("FAIL rst_tick got=%b exp=0", tick_o); end
        if (clk_div_o !== 1'b0)  begin bad++; $display("FAIL rst_clkdiv got=%b exp=0", clk_div_o); end
        if (cfg_err_o !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b exp=0", cfg_err_o); end
        if (busy_o !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cfg_ready_o); end
        if (div_cur_o !== 8'd7)  begin bad++; $display("FAIL rst_div got=%0d exp=7", div_cur_o); end
        rst_i = 1'b0; en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (busy_o !== 1'b0 || clk_div_o !== 1'b0) begin
                bad++; $display("FAIL idle_hold got=%b%b exp=00", busy_o, clk_div_o);
            end
        end
    endtask

    task automatic test_default_run();
        int p0;
        start_run(p0);
        for (int k = 0; k < 3; k++) exp_q.push_back(p0 + 6 + 7 * k);
        for (int i = 0; i < 21; i++) begin
            if (i > 0) step();
            total += 2;
            if (clk_div_o !== ((i % 7) < 3)) begin
                bad++; $display("FAIL default_wave i=%0d got=%b exp=%b", i, clk_div_o, (i % 7) < 3);
            end
            if (busy_o !== 1'b1 || div_cur_o !== 8'd7) begin
                bad++; $display("FAIL default_state i=%0d got=%b/%0d exp=1/7", i, busy_o, div_cur_o);
            end
        end
        drain("default");
    endtask

    // 7 -> 4 mid-period, then an immediate back-to-back 4 -> 3 update.
    task automatic test_update_mid();
        int p0;
        start_run(p0);
        exp_q.push_back(p0 + 6);
        exp_q.push_back(p0 + 10);
        exp_q.push_back(p0 + 13);
        exp_q.push_back(p0 + 16);
        step(); step();
        cfg_valid_i = 1'b1; cfg_div_i = 8'd4;
        step();
        cfg_valid_i = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            if (c > 3) step();
            total++;
            if (cfg_ready_o !== 1'b0 || clk_div_o !== 1'b0 || div_cur_o !== 8'd7) begin
                bad++; $display("FAIL upd_pend c=%0d got=%b%b/%0d exp=00/7", c, cfg_ready_o, clk_div_o, div_cur_o);
            end
        end
        step();
        total++;
        if (cfg_ready_o !== 1'b1 || div_cur_o !== 8'd4) begin
            bad++; $display("FAIL upd_apply got=%b/%0d exp=1/4", cfg_ready_o, div_cur_o);
        end
        cfg_valid_i = 1'b1; cfg_div_i = 8'd3;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (i == 1) cfg_valid_i = 1'b0;
            total++;
            if (clk_div_o !== ((i < 4) ? ((i % 4) < 2) : (((i - 4) % 3) < 1))) begin
                bad++; $display("FAIL upd_wave i=%0d got=%b", i, clk_div_o);
            end
        end
        total++;
        if (div_cur_o !== 8'd3) begin bad++; $display("FAIL b2b_div got=%0d exp=3", div_cur_o); end
        drain("update_mid");
    endtask

    task automatic test_bad_cfg();
        int p0;
        start_run(p0);
        exp_q.push_back(p0 + 6);
        exp_q.push_back(p0 + 13);
        step();
        total++;
        if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL err_idle got=%b exp=0", cfg_err_o); end
        cfg_valid_i = 1'b1; cfg_div_i = 8'd1;
        step();
        cfg_valid_i = 1'b0;
        total += 3;
        if (cfg_err_o !== 1'b1)   begin bad++; $display("FAIL err_pulse got=%b exp=1", cfg_err_o); end
        if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL err_ready got=%b exp=1", cfg_ready_o); end
        if (div_cur_o !== 8'd7)   begin bad++; $display("FAIL err_div got=%0d exp=7", div_cur_o); end
        step();
        total++;
        if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL err_width got=%b exp=0", cfg_err_o); end
        for (int c = 4; c <= 13; c++) step();
        drain("bad_cfg");
    endtask

    task automatic test_boundary_xfer();
        int p0;
        start_run(p0);
        exp_q.push_back(p0 + 6);
        exp_q.push_back(p0 + 13);
        exp_q.push_back(p0 + 18);
        exp_q.push_back(p0 + 23);
        for (int c = 1; c <= 6; c++) step();
        cfg_valid_i = 1'b1; cfg_div_i = 8'd5;
        step();
        cfg_valid_i = 1'b0;
        total++;
        if (cfg_ready_o !== 1'b0 || div_cur_o !== 8'd7) begin
            bad++; $display("FAIL bnd_defer got=%b/%0d exp=0/7", cfg_ready_o, div_cur_o);
        end
        for (int c = 8; c <= 14; c++) step();
        total++;
        if (cfg_ready_o !== 1'b1 || div_cur_o !== 8'd5) begin
            bad++; $display("FAIL bnd_apply got=%b/%0d exp=1/5", cfg_ready_o, div_cur_o);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            total++;
            if (clk_div_o !== ((i % 5) < 2)) begin
                bad++; $display("FAIL bnd_wave i=%0d got=%b exp=%b", i, clk_div_o, (i % 5) < 2);
            end
        end
        drain("boundary");
    endtask

    task automatic test_stop_restart();
        int p1;
        rst_i = 1'b1; en_i = 1'b0; cfg_valid_i = 1'b0;
        step(); step();
        rst_i = 1'b0; cfg_valid_i = 1'b1; cfg_div_i = 8'd6;
        step();
        cfg_valid_i = 1'b0;
        total++;
        if (div_cur_o !== 8'd6 || busy_o !== 1'b0) begin
            bad++; $display("FAIL idle_cfg got=%0d/%b exp=6/0", div_cur_o, busy_o);
        end
        en_i = 1'b1;
        step();
        exp_q.push_back(cyc + 5);
        step(); step();
        en_i = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            step();
            total++;
            if (busy_o !== 1'b1) begin bad++; $display("FAIL stop_finish c=%0d got=%b exp=1", c, busy_o); end
        end
        for (int c = 6; c <= 8; c++) begin
            step();
            total++;
            if (busy_o !== 1'b0 || clk_div_o !== 1'b0 || tick_o !== 1'b0) begin
                bad++; $display("FAIL stop_idle c=%0d got=%b%b%b exp=000", c, busy_o, clk_div_o, tick_o);
            end
        end
        en_i = 1'b1;
        step();
        p1 = cyc;
        exp_q.push_back(p1 + 5);
        exp_q.push_back(p1 + 11);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            total++;
            if (clk_div_o !== ((i % 6) < 3)) begin
                bad++; $display("FAIL restart_wave i=%0d got=%b exp=%b", i, clk_div_o, (i % 6) < 3);
            end
        end
        drain("stop_restart");
    endtask

    task automatic test_reset_pend();
        int p0, p1;
        start_run(p0);
        step();
        cfg_valid_i = 1'b1; cfg_div_i = 8'd3;
        step();
        cfg_valid_i = 1'b0;
        total++;
        if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL rp_pend got=%b exp=0", cfg_ready_o); end
        step();
        rst_i = 1'b1;
        step();
        total++;
        if ({tick_o, clk_div_o, busy_o, cfg_err_o, cfg_ready_o} !== 5'b00001 || div_cur_o !== 8'd7) begin
            bad++; $display("FAIL rp_reset got=%b%b%b%b%b/%0d exp=00001/7",
                            tick_o, clk_div_o, busy_o, cfg_err_o, cfg_ready_o, div_cur_o);
        end
        rst_i = 1'b0;
        step();
        p1 = cyc;
        exp_q.push_back(p1 + 6);
        exp_q.push_back(p1 + 13);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            total++;
            if (div_cur_o !== 8'd7 || clk_div_o !== ((i % 7) < 3)) begin
                bad++; $display("FAIL rp_lost i=%0d got=%0d/%b exp=7/%b", i, div_cur_o, clk_div_o, (i % 7) < 3);
            end
        end
        drain("reset_pend");
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_update_mid();
        test_bad_cfg();
        test_boundary_xfer();
        test_stop_restart();
        test_reset_pend();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
